uart_rx_param: RTL and testbench
================================

Name:
uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Frame format: configurable data width, parity mode and stop-bit count.
- Free-running start-bit detection: no per-byte request needed.
- Received words are presented on a valid/ready output handshake, with per-word framing and parity error flags and an overrun indication.
- Sits between the pad-side rx line and the controller's register or FIFO layer.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BIT_RATE, 9600, line bit rate in baud
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk_i  input  1  system clock; all logic on rising edge
nreset_i  input  1  reset, synchronous, active-low
rx_i  input  1  serial line, idle high
data_o  output  DATA_BITS  received word, LSB = first data bit on the line
valid_o  output  1  data_o and error flags hold a word
ready_i  input  1  consumer accepts word when valid_o && ready_i
frame_err_o  output  1  a stop bit of the held word sampled low; qualified by valid_o
parity_err_o  output  1  parity mismatch on the held word; qualified by valid_o; always 0 when PARITY = 0
overrun_o  output  1  one-cycle pulse: a frame completed while the held word was not accepted
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (nreset_i low at a rising edge): FSM to IDLE, data_o = all ones, valid_o = 0, frame_err_o = 0, parity_err_o = 0, overrun_o = 0, busy_o = 0.
- Reset mid-frame or with valid_o high: the partial frame and the held word are discarded.
- CPB = CLK_HZ / BIT_RATE, integer division.
- Bit counter width = $clog2(CPB) + 1; cycle counter likewise sized.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: rx_i == 0 sampled -> START; cycle counter cleared.
- START: sample rx_i when counter == CPB/2 - 1, i.e. CPB/2 cycles after detection.
  - If rx_i == 1: glitch; return to IDLE with no output, no flags.
  - Else go to DATA; counter cleared.
- Sampling rule: every later sample occurs exactly CPB cycles after the previous sample (counter wraps at CPB - 1).
- DATA: DATA_BITS samples shifted LSB first -> PAR if PARITY != 0, else STOP.
- PAR: one sample. Odd parity: the data bits plus the parity bit must contain an odd number of ones. Even parity: an even number.
- STOP: STOP_BITS samples; any low sample sets the frame error for this frame.
- On the last stop sample the FSM returns to IDLE in the same cycle, so a new start edge is detectable half a bit early.
- Completion cycle (last stop sample) C, resolved on edge C+1:
  - If valid_o == 0, or ready_i == 1 in cycle C: load data_o, frame_err_o and parity_err_o; valid_o = 1 from C+1.
  - Else (valid_o && !ready_i): new frame dropped; held word and flags unchanged; overrun_o = 1 for cycle C+1 only.
- Handshake: valid_o, data_o and the flags are stable while valid_o && !ready_i. valid_o deasserts on the edge after acceptance unless a new word loads on that same edge.
- Latency, 8N1 with CPB = 10: start detected in cycle T.
  - Data samples at T+15 .. T+85.
  - Stop sample at T+95.
  - valid_o high at T+96.

Optional Feature:
UART_RX_SYNC_EN:
- Defined: rx_i passes through a two-flop synchroniser, both flops reset to 1, before the FSM. All sample times shift +2 cycles.
- Undefined: rx_i is used directly and must already be synchronous to clk_i.

Test Plan:
- CLK_HZ = 100e6, BIT_RATE = 10e6, 8N1; send 0xA5, ready_i = 1 -> valid_o for one cycle, data_o = 0xA5, frame_err_o = 0, parity_err_o = 0, valid_o rises 96 cycles after start detect.
- Same setup; rx_i low for 3 cycles only -> back to IDLE, busy_o low at T+5, no valid_o.
- PARITY = 2; send 0x07 with parity bit 0 -> parity_err_o = 1 with data_o = 0x07. With parity bit 1 -> parity_err_o = 0.
- STOP_BITS = 2; second stop bit driven low -> frame_err_o = 1 with data_o correct.
- ready_i = 0; send 0x11 then 0x22 -> data_o stays 0x11, one-cycle overrun_o at completion of 0x22. Raise ready_i in the 0x33 completion cycle -> data_o = 0x33, no overrun, valid_o stays high.
- nreset_i low at mid-DATA of a frame -> next edge: busy_o = 0, valid_o = 0, data_o = 0xFF. The following clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data bits, parity and stop bits, valid/ready output with error flags.
// Optional UART_RX_SYNC_EN inserts a two-flop synchroniser on rx_i (all sample times shift by +2 cycles).
module uart_rx_param #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned BIT_RATE  = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 nreset_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int unsigned CPB   = CLK_HZ / BIT_RATE;
   localparam int unsigned CNT_W = $clog2(CPB) + 1;
   localparam int unsigned BIT_W = (CNT_W > 4) ? CNT_W : 4;
   localparam bit          ODD   = (PARITY == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   // Two-flop synchroniser; idle-high reset value avoids a false start after reset.
   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_i};
      end
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = rx_i;
`endif

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic [DATA_BITS-1:0] data_d;
   logic                 valid_d, fe_d, pe_d, ovr_d, busy_d;
   logic                 tick, done;

   assign tick = (cnt_q == CNT_W'(CPB - 1));

   // Next-state, shift/flag accumulation and output-register update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      data_d  = data_o;
      valid_d = valid_o & ~ready_i;
      fe_d    = frame_err_o;
      pe_d    = parity_err_o;
      ovr_d   = 1'b0;
      done    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
               ferr_d  = 1'b0;
               perr_d  = 1'b0;
            end
         end
         START: begin
            if (cnt_q == CNT_W'(CPB / 2 - 1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         PAR: begin
            if (tick) begin
               cnt_d   = '0;
               bit_d   = '0;
               perr_d  = (^shift_q) ^ rx_s ^ ODD;
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               cnt_d  = '0;
               ferr_d = ferr_q | ~rx_s;
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  done    = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Completed frame either loads the output slot or is dropped as an overrun
      if (done) begin
         if (!valid_o || ready_i) begin
            data_d  = shift_q;
            fe_d    = ferr_d;
            pe_d    = perr_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         ferr_q       <= 1'b0;
         perr_q       <= 1'b0;
         data_o       <= '1;
         valid_o      <= 1'b0;
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         ferr_q       <= ferr_d;
         perr_q       <= perr_d;
         data_o       <= data_d;
         valid_o      <= valid_d;
         frame_err_o  <= fe_d;
         parity_err_o <= pe_d;
         overrun_o    <= ovr_d;
         busy_o       <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 8E1 and 8N2 instances at 10 clocks per bit.
module tb_uart_rx_param;

   localparam int unsigned CLK_HZ   = 100_000_000;
   localparam int unsigned BIT_RATE = 10_000_000;
`ifdef UART_RX_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       pe;
   } word_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] rx, ready, valid, busy, fe, pe, ovr;
   logic [7:0] data0, data1, data2;

   always #5 clk = ~clk;

   uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk_i(clk), .nreset_i(rst_n), .rx_i(rx[0]), .data_o(data0), .valid_o(valid[0]), .ready_i(ready[0]),
      .frame_err_o(fe[0]), .parity_err_o(pe[0]), .overrun_o(ovr[0]), .busy_o(busy[0]));

   uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
      .clk_i(clk), .nreset_i(rst_n), .rx_i(rx[1]), .data_o(data1), .valid_o(valid[1]), .ready_i(ready[1]),
      .frame_err_o(fe[1]), .parity_err_o(pe[1]), .overrun_o(ovr[1]), .busy_o(busy[1]));

   uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
      .clk_i(clk), .nreset_i(rst_n), .rx_i(rx[2]), .data_o(data2), .valid_o(valid[2]), .ready_i(ready[2]),
      .frame_err_o(fe[2]), .parity_err_o(pe[2]), .overrun_o(ovr[2]), .busy_o(busy[2]));

   word_t exp0[$], exp1[$], exp2[$];
   word_t obs0[$], obs1[$], obs2[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    ovr_cnt[3] = '{0, 0, 0};
   int    acc[3]     = '{0, 0, 0};

   // Capture every accepted word and every overrun cycle
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (valid[0] && ready[0]) begin obs0.push_back({data0, fe[0], pe[0]}); acc[0]++; end
         if (valid[1] && ready[1]) begin obs1.push_back({data1, fe[1], pe[1]}); acc[1]++; end
         if (valid[2] && ready[2]) begin obs2.push_back({data2, fe[2], pe[2]}); acc[2]++; end
         for (int i = 0; i < 3; i++) if (ovr[i]) ovr_cnt[i]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_size(input int d);
      case (d)
         0: return exp0.size();
         1: return exp1.size();
         default: return exp2.size();
      endcase
   endfunction

   function automatic int obs_size(input int d);
      case (d)
         0: return obs0.size();
         1: return obs1.size();
         default: return obs2.size();
      endcase
   endfunction

   task automatic drain(input int d);
      word_t o, e;
      while (obs_size(d) > 0) begin
         case (d)
            0: o = obs0.pop_front();
            1: o = obs1.pop_front();
            default: o = obs2.pop_front();
         endcase
         chk($sformatf("sb%0d_pending", d), 32'(exp_size(d) > 0), 1);
         if (exp_size(d) > 0) begin
            case (d)
               0: e = exp0.pop_front();
               1: e = exp1.pop_front();
               default: e = exp2.pop_front();
            endcase
            chk($sformatf("sb%0d_data", d), 32'(o.data), 32'(e.data));
            chk($sformatf("sb%0d_frame_err", d), 32'(o.fe), 32'(e.fe));
            chk($sformatf("sb%0d_parity_err", d), 32'(o.pe), 32'(e.pe));
         end
      end
   endtask

   task automatic drive_bit(input int d, input logic v);
      @(posedge clk);
      #1 rx[d] = v;
      repeat (9) @(posedge clk);
   endtask

   // One frame; optionally raises ready exactly in the completion cycle
   task automatic send(input int d, input logic [7:0] v, input bit par, input logic pbit,
                       input bit two_stop, input logic s1, input logic s2,
                       input bit expect_word, input bit raise_rdy);
      word_t e;
      logic  last;
      e.data = v;
      e.fe   = ~s1 | (two_stop & ~s2);
      e.pe   = par & ((^v) ^ pbit);
      if (expect_word) begin
         case (d)
            0: exp0.push_back(e);
            1: exp1.push_back(e);
            default: exp2.push_back(e);
         endcase
      end
      drive_bit(d, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d, v[i]);
      if (par) drive_bit(d, pbit);
      if (two_stop) begin
         drive_bit(d, s1);
         last = s2;
      end else begin
         last = s1;
      end
      if (raise_rdy) begin
         @(posedge clk);
         #1 rx[d] = last;
         repeat (5 + S) @(posedge clk);
         #1 ready[d] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("handoff_valid", 32'(valid[0]), 1);
         chk("handoff_data", 32'(data0), 32'(v));
         chk("handoff_no_overrun", 32'(ovr[0]), 0);
         repeat (3 - S) @(posedge clk);
      end else begin
         drive_bit(d, last);
      end
      @(posedge clk);
      #1 rx[d] = 1'b1;
      repeat (15) @(posedge clk);
   endtask

   initial begin
      int         acc_before;
      logic [7:0] pats [6] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hC3};

      rst_n = 1'b0;
      rx    = 3'b111;
      ready = 3'b111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data0", 32'(data0), 32'hFF);
      chk("rst_valid0", 32'(valid[0]), 0);
      chk("rst_busy0", 32'(busy[0]), 0);
      chk("rst_flags0", 32'({fe[0], pe[0], ovr[0]}), 0);
      chk("rst_data1", 32'(data1), 32'hFF);
      chk("rst_data2", 32'(data2), 32'hFF);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // First frame with exact valid_o rise time
      fork
         send(0, 8'hA5, 0, 1'b0, 0, 1'b1, 1'b1, 1, 0);
         begin
            @(posedge clk);
            repeat (95 + S) @(posedge clk);
            @(negedge clk);
            chk("latency_before", 32'(valid[0]), 0);
            @(posedge clk);
            @(negedge clk);
            chk("latency_rise", 32'(valid[0]), 1);
         end
      join
      drain(0);
      chk("single_cycle_valid", 32'(acc[0]), 1);

      foreach (pats[i]) send(0, pats[i], 0, 1'b0, 0, 1'b1, 1'b1, 1, 0);
      drain(0);

      // Three-cycle low glitch must not produce a word
      acc_before = acc[0];
      @(posedge clk);
      #1 rx[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx[0] = 1'b1;
      @(negedge clk);
      chk("glitch_busy_high", 32'(busy[0]), 1);
      repeat (3 + S) @(posedge clk);
      @(negedge clk);
      chk("glitch_busy_low", 32'(busy[0]), 0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("glitch_no_word", 32'(acc[0]), 32'(acc_before));

      // Even parity
      send(1, 8'h07, 1, 1'b0, 0, 1'b1, 1'b1, 1, 0);
      send(1, 8'h07, 1, 1'b1, 0, 1'b1, 1'b1, 1, 0);
      send(1, 8'hC3, 1, 1'b0, 0, 1'b1, 1'b1, 1, 0);
      send(1, 8'hC3, 1, 1'b1, 0, 1'b1, 1'b1, 1, 0);
      drain(1);

      // Two stop bits
      send(2, 8'h5A, 0, 1'b0, 1, 1'b1, 1'b0, 1, 0);
      send(2, 8'h96, 0, 1'b0, 1, 1'b1, 1'b1, 1, 0);
      send(2, 8'h81, 0, 1'b0, 1, 1'b0, 1'b1, 1, 0);
      drain(2);

      // Overrun while the held word is not accepted
      ready[0] = 1'b0;
      chk("ovr_none_yet", 32'(ovr_cnt[0]), 0);
      send(0, 8'h11, 0, 1'b0, 0, 1'b1, 1'b1, 1, 0);
      send(0, 8'h22, 0, 1'b0, 0, 1'b1, 1'b1, 0, 0);
      @(negedge clk);
      chk("ovr_pulse_count", 32'(ovr_cnt[0]), 1);
      chk("ovr_held_data", 32'(data0), 32'h11);
      chk("ovr_held_valid", 32'(valid[0]), 1);
      send(0, 8'h33, 0, 1'b0, 0, 1'b1, 1'b1, 1, 1);
      drain(0);
      chk("ovr_after_handoff", 32'(ovr_cnt[0]), 1);

      // Reset mid-DATA with a word held
      ready[0] = 1'b0;
      send(0, 8'h5A, 0, 1'b0, 0, 1'b1, 1'b1, 1, 0);
      @(negedge clk);
      chk("held_before_reset", 32'(valid[0]), 1);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      #1;
      rx[0] = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_valid", 32'(valid[0]), 0);
      chk("midrst_data", 32'(data0), 32'hFF);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp0.delete();
      ready[0] = 1'b1;
      repeat (5) @(posedge clk);
      send(0, 8'h3C, 0, 1'b0, 0, 1'b1, 1'b1, 1, 0);
      drain(0);

      chk("sb0_empty", 32'(exp_size(0)), 0);
      chk("sb1_empty", 32'(exp_size(1)), 0);
      chk("sb2_empty", 32'(exp_size(2)), 0);
      chk("no_ovr_dut1", 32'(ovr_cnt[1]), 0);
      chk("no_ovr_dut2", 32'(ovr_cnt[2]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
